// File: rtl/alu_result_tx.sv
// ALU result transmitter: queues {flags, result} entries and sends each one as a byte frame to the UART tx.
// Optional TX_CHECKSUM_EN appends a third byte, B0 XOR B1, to every frame.
module alu_result_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_SIZE  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_zero,
  input  logic                  i_carry,
  input  logic                  i_overflow,
  input  logic                  i_negative,
  input  logic                  i_exception,
  input  logic                  i_valid,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_drop
);

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned ENTRY_W = DATA_WIDTH + FLAG_W;
  localparam int unsigned PTR_W   = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_RES  = 3'd1,
    WAIT_RES  = 3'd2,
    SEND_STAT = 3'd3,
    WAIT_STAT = 3'd4
`ifdef TX_CHECKSUM_EN
    ,
    SEND_CHK  = 3'd5,
    WAIT_CHK  = 3'd6
`endif
  } state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0] mem [FIFO_SIZE];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [ENTRY_W-1:0] entry_c, head_c;
  logic               full_c, pop_c, push_c, drop_c;
  logic [FLAG_W-1:0]  frame_status;
`ifdef TX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] frame_result;
`endif

  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  tx_start_d, busy_d;

  assign entry_c = {i_exception, i_negative, i_overflow, i_carry, i_zero, i_result};
  assign head_c  = mem[rd_ptr];

  // A pop frees a slot on the same edge, so a push into a full queue is only refused when no pop happens.
  always_comb begin
    full_c = (count == CNT_W'(FIFO_SIZE));
    pop_c  = (state == IDLE) && (count != '0);
    push_c = i_valid && (!full_c || pop_c);
    drop_c = i_valid && full_c && !pop_c;
    case ({push_c, pop_c})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push_c) mem[wr_ptr] <= entry_c;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
      o_drop  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      o_full  <= (count_next == CNT_W'(FIFO_SIZE));
      o_empty <= (count_next == '0);
      o_drop  <= drop_c;
    end
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; i_tx_done only matters in WAIT states
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop_c) state_next = SEND_RES;
      SEND_RES:  state_next = WAIT_RES;
      WAIT_RES:  if (i_tx_done) state_next = SEND_STAT;
      SEND_STAT: state_next = WAIT_STAT;
`ifdef TX_CHECKSUM_EN
      WAIT_STAT: if (i_tx_done) state_next = SEND_CHK;
      SEND_CHK:  state_next = WAIT_CHK;
      WAIT_CHK:  if (i_tx_done) state_next = IDLE;
`else
      WAIT_STAT: if (i_tx_done) state_next = IDLE;
`endif
      default:   state_next = IDLE;
    endcase
  end

  // Output logic: registered outputs follow the state being entered
  always_comb begin
    tx_data_d  = o_tx_data;
    tx_start_d = 1'b0;
    busy_d     = (state_next != IDLE);
    case (state_next)
      SEND_RES: begin
        tx_data_d  = head_c[DATA_WIDTH-1:0];
        tx_start_d = 1'b1;
      end
      SEND_STAT: begin
        tx_data_d  = DATA_WIDTH'(frame_status);
        tx_start_d = 1'b1;
      end
`ifdef TX_CHECKSUM_EN
      SEND_CHK: begin
        tx_data_d  = frame_result ^ DATA_WIDTH'(frame_status);
        tx_start_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      frame_status <= '0;
`ifdef TX_CHECKSUM_EN
      frame_result <= '0;
`endif
    end else begin
      o_tx_data  <= tx_data_d;
      o_tx_start <= tx_start_d;
      o_busy     <= busy_d;
      if (pop_c) begin
        frame_status <= head_c[ENTRY_W-1:DATA_WIDTH];
`ifdef TX_CHECKSUM_EN
        frame_result <= head_c[DATA_WIDTH-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: vector table, hand-written corner sequences and a random run against a queue model.
// Honours TX_CHECKSUM_EN the same way as the design.
module tb_alu_result_tx;

  localparam int DW = 8;
  localparam int FS = 4;
`ifdef TX_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int NRAND = 40;

  logic          i_clock, i_reset;
  logic [DW-1:0] i_result;
  logic          i_zero, i_carry, i_overflow, i_negative, i_exception;
  logic          i_valid, i_tx_done;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_start, o_busy, o_full, o_empty, o_drop;

  alu_result_tx #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_result(i_result),
    .i_zero(i_zero), .i_carry(i_carry), .i_overflow(i_overflow),
    .i_negative(i_negative), .i_exception(i_exception),
    .i_valid(i_valid), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_full(o_full), .o_empty(o_empty), .o_drop(o_drop)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int completed = 0;

  typedef struct {
    logic [7:0] res;
    logic [4:0] fl;   // {exception, negative, overflow, carry, zero}
    logic [7:0] b0, b1, b2;
    int         delay;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [4:0] fl;
  } entry_t;

  vec_t   vecs [6];
  entry_t model_q [$];

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(input string name);
    int t = 0;
    while (!o_tx_start && t < 200) begin
      tick();
      t++;
    end
    check(name, 32'(o_tx_start), 1);
  endtask

  task automatic push(input logic [7:0] res, input logic [4:0] fl);
    i_result = res;
    {i_exception, i_negative, i_overflow, i_carry, i_zero} = fl;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // Acts as the UART tx: takes each byte, waits `delay` cycles, answers with i_tx_done.
  task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input bit skip_b0, input int delay,
                              input bit idle_push, input logic [7:0] push_res);
    logic [7:0] bytes [3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    for (int k = 0; k < NB; k++) begin
      if (!(k == 0 && skip_b0)) begin
        wait_start("frame_start");
        check("frame_byte", 32'(o_tx_data), 32'(bytes[k]));
        tick();
      end
      for (int d = 0; d < delay; d++) begin
        check("wait_no_start", 32'(o_tx_start), 0);
        check("wait_data_hold", 32'(o_tx_data), 32'(bytes[k]));
        tick();
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
    check("frame_end_idle", 32'(o_busy), 0);
    if (idle_push) push(push_res, 5'b00000);
  endtask

  initial begin
    bit seen;
    entry_t e;

    vecs[0] = '{res: 8'h2A, fl: 5'b00010, b0: 8'h2A, b1: 8'h02, b2: 8'h28, delay: 0};
    vecs[1] = '{res: 8'h00, fl: 5'b10001, b0: 8'h00, b1: 8'h11, b2: 8'h11, delay: 2};
    vecs[2] = '{res: 8'hFF, fl: 5'b01110, b0: 8'hFF, b1: 8'h0E, b2: 8'hF1, delay: 1};
    vecs[3] = '{res: 8'h80, fl: 5'b01100, b0: 8'h80, b1: 8'h0C, b2: 8'h8C, delay: 3};
    vecs[4] = '{res: 8'h55, fl: 5'b00000, b0: 8'h55, b1: 8'h00, b2: 8'h55, delay: 0};
    vecs[5] = '{res: 8'hC3, fl: 5'b11111, b0: 8'hC3, b1: 8'h1F, b2: 8'hDC, delay: 1};

    i_reset = 1'b1; i_result = '0; i_zero = 0; i_carry = 0; i_overflow = 0;
    i_negative = 0; i_exception = 0; i_valid = 0; i_tx_done = 0;
    tick();
    tick();
    check("rst_tx_data", 32'(o_tx_data), 0);
    check("rst_tx_start", 32'(o_tx_start), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_full", 32'(o_full), 0);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_drop", 32'(o_drop), 0);
    i_reset = 1'b0;
    tick();

    // Single-result frames: latency N+2 to o_tx_start, then the byte sequence
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].res, vecs[v].fl);
      check("lat_n1_no_start", 32'(o_tx_start), 0);
      check("lat_n1_not_empty", 32'(o_empty), 0);
      check("lat_n1_idle", 32'(o_busy), 0);
      tick();
      check("lat_n2_start", 32'(o_tx_start), 1);
      check("lat_n2_data", 32'(o_tx_data), 32'(vecs[v].b0));
      check("lat_n2_busy", 32'(o_busy), 1);
      check("lat_n2_empty", 32'(o_empty), 1);
      tick();
      expect_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, 1'b1, vecs[v].delay, 1'b0, 8'h00);
      tick();
    end

    // Premature done: in IDLE, and in the same cycle as o_tx_start
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("pre_idle_no_start", 32'(o_tx_start), 0);
    check("pre_idle_not_busy", 32'(o_busy), 0);
    push(8'h5A, 5'b01000);
    tick();
    check("pre_start", 32'(o_tx_start), 1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("pre_still_wait_start", 32'(o_tx_start), 0);
      check("pre_still_wait_busy", 32'(o_busy), 1);
      check("pre_still_wait_data", 32'(o_tx_data), 32'h5A);
      tick();
    end
    expect_frame(8'h5A, 8'h08, 8'h52, 1'b1, 0, 1'b0, 8'h00);
    tick();

    // Fill and drop: 01 in flight, 02..05 queued, 06 dropped
    push(8'h01, 5'b00000);
    tick();
    check("fill_first_start", 32'(o_tx_start), 1);
    check("fill_first_data", 32'(o_tx_data), 32'h01);
    tick();
    for (int i = 2; i <= 5; i++) begin
      push(8'(i), 5'b00000);
      check("fill_no_drop", 32'(o_drop), 0);
    end
    check("fill_full", 32'(o_full), 1);
    check("fill_not_empty", 32'(o_empty), 0);
    push(8'h06, 5'b00000);
    check("drop_pulse", 32'(o_drop), 1);
    check("drop_still_full", 32'(o_full), 1);
    tick();
    check("drop_one_cycle", 32'(o_drop), 0);
    expect_frame(8'h01, 8'h00, 8'h01, 1'b1, 1, 1'b0, 8'h00);
    for (int i = 2; i <= 5; i++)
      expect_frame(8'(i), 8'h00, 8'(i), 1'b0, 0, 1'b0, 8'h00);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (o_tx_start) seen = 1'b1;
      tick();
    end
    check("dropped_never_sent", 32'(seen), 0);
    check("fill_drained_empty", 32'(o_empty), 1);

    // Push and pop on the same edge with the queue full
    push(8'h10, 5'b00000);
    tick();
    check("pp_first_start", 32'(o_tx_start), 1);
    tick();
    for (int i = 1; i <= 4; i++) push(8'h10 + 8'(i), 5'b00000);
    check("pp_full", 32'(o_full), 1);
    expect_frame(8'h10, 8'h00, 8'h10, 1'b1, 1, 1'b1, 8'h15);
    check("pp_next_start", 32'(o_tx_start), 1);
    check("pp_next_data", 32'(o_tx_data), 32'h11);
    check("pp_count_stays_full", 32'(o_full), 1);
    check("pp_no_drop", 32'(o_drop), 0);
    for (int i = 1; i <= 5; i++)
      expect_frame(8'h10 + 8'(i), 8'h00, 8'h10 + 8'(i), 1'b0, 0, 1'b0, 8'h00);
    tick();

    // Randomised traffic against a FIFO-of-frames model
    fork
      begin : producer
        int cyc = 0;
        while (pushed < NRAND && cyc < 20000) begin
          if ((pushed - completed) < FS && $urandom_range(0, 2) == 0) begin
            e.res = 8'($urandom);
            e.fl  = 5'($urandom);
            model_q.push_back(e);
            i_result = e.res;
            {i_exception, i_negative, i_overflow, i_carry, i_zero} = e.fl;
            i_valid = 1'b1;
            pushed++;
          end else begin
            i_valid = 1'b0;
          end
          tick();
          check("rand_no_drop", 32'(o_drop), 0);
          cyc++;
        end
        i_valid = 1'b0;
      end
      begin : consumer
        entry_t c;
        logic [7:0] st;
        for (int f = 0; f < NRAND; f++) begin
          wait_start("rand_start");
          if (model_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_model: frame started with no result pending (t=%0t)", $time);
            f = NRAND;
          end else begin
            c  = model_q.pop_front();
            st = {3'b000, c.fl};
            expect_frame(c.res, st, c.res ^ st, 1'b0, int'($urandom_range(0, 3)), 1'b0, 8'h00);
            completed++;
          end
        end
      end
    join
    check("rand_all_sent", 32'(completed), 32'(NRAND));
    tick();

    // Reset while waiting for the status byte, with another entry queued
    push(8'h3C, 5'b01010);
    tick();
    check("rm_start", 32'(o_tx_start), 1);
    check("rm_b0", 32'(o_tx_data), 32'h3C);
    tick();
    push(8'h77, 5'b00000);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("rm_stat_start", 32'(o_tx_start), 1);
    check("rm_stat_data", 32'(o_tx_data), 32'h0A);
    tick();
    check("rm_wait_busy", 32'(o_busy), 1);
    check("rm_wait_not_empty", 32'(o_empty), 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rm_busy", 32'(o_busy), 0);
    check("rm_empty", 32'(o_empty), 1);
    check("rm_full", 32'(o_full), 0);
    check("rm_no_start", 32'(o_tx_start), 0);
    check("rm_data", 32'(o_tx_data), 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 15; t++) begin
      if (o_tx_start || o_busy) seen = 1'b1;
      tick();
    end
    check("rm_late_done_ignored", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
